// File: rtl/vga_console_palette_pkg.sv
// Shared types and default-palette helper for the VGA console colour LUT.
package vga_console_palette_pkg;

    // Widest packed {R,G,B} word default_color can return.
    localparam int unsigned DEF_W = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Level of one channel: zero, MSB only (half-scale) or all ones (full-scale).
    function automatic logic [DEF_W-1:0] chan_level(
        input logic        active,
        input logic        half,
        input int unsigned w
    );
        logic [DEF_W-1:0] level;
        level = '0;
        if (active) begin
            if (half) begin
                level = DEF_W'(1) << (w - 1);
            end else begin
                level = (DEF_W'(1) << w) - DEF_W'(1);
            end
        end
        return level;
    endfunction

    // Power-on colour for entry k, right-aligned as {R,G,B}.
    function automatic logic [DEF_W-1:0] default_color(
        input int unsigned k,
        input int unsigned idx_w,
        input int unsigned r_w,
        input int unsigned g_w,
        input int unsigned b_w
    );
        logic [DEF_W-1:0] color;
        logic             half;
        half = (idx_w >= 4) && !k[3];
        if (k == 0) begin
            color = (DEF_W'(1) << (r_w + g_w + b_w)) - DEF_W'(1);
        end else if (k == 1) begin
            color = '0;
        end else begin
            color = (chan_level(k[2], half, r_w) << (g_w + b_w))
                  | (chan_level(k[1], half, g_w) << b_w)
                  |  chan_level(k[0], half, b_w);
        end
        return color;
    endfunction

endpackage

// File: rtl/vga_console_palette_ram.sv
// Simple dual-port palette storage: synchronous write, registered read,
// read returns the old word when both ports hit the same entry.
module vga_console_palette_ram #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_console_palette_lut.sv
// Programmable VGA console colour LUT with default-palette init sequencer.
// Optional per-entry blink bit enabled by VGA_CONSOLE_PALETTE_BLINK_EN.
module vga_console_palette_lut
    import vga_console_palette_pkg::*;
#(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned R_W   = 3,
    parameter int unsigned G_W   = 3,
    parameter int unsigned B_W   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pix_valid,
    input  logic [IDX_W-1:0]           color_idx,
    output logic                       rgb_valid,
    output logic [R_W+G_W+B_W-1:0]     rgb,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_addr,
    input  logic [R_W+G_W+B_W-1:0]     wr_data,
`ifdef VGA_CONSOLE_PALETTE_BLINK_EN
    input  logic                       blink_phase,
    input  logic                       wr_blink,
`endif
    output logic                       wr_ready,
    output logic                       init_busy
);

    localparam int unsigned ENTRIES = 2 ** IDX_W;
    localparam int unsigned RGB_W   = R_W + G_W + B_W;
`ifdef VGA_CONSOLE_PALETTE_BLINK_EN
    localparam int unsigned MEM_W   = RGB_W + 1;
`else
    localparam int unsigned MEM_W   = RGB_W;
`endif

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   init_addr_q, init_addr_d;
    logic               init_busy_q, wr_ready_q;

    logic               ram_we_c;
    logic [IDX_W-1:0]   ram_waddr_c;
    logic [MEM_W-1:0]   ram_wdata_c;
    logic [MEM_W-1:0]   user_word_c;
    logic [MEM_W-1:0]   init_word_c;
    logic [MEM_W-1:0]   rd_data;

    logic               valid_s1_q, rgb_valid_q;
    logic               init_s1_q;
    logic [RGB_W-1:0]   rgb_q, rgb_d;
`ifdef VGA_CONSOLE_PALETTE_BLINK_EN
    logic               blink_s1_q;

    assign user_word_c = {wr_blink, wr_data};
`else
    assign user_word_c = wr_data;
`endif

    // Default entries never set the blink bit; the upper bits are zero.
    assign init_word_c = MEM_W'(default_color(32'(init_addr_q), IDX_W, R_W, G_W, B_W));

    // Next-state logic and write-port mux: sequencer owns the port during INIT.
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        ram_we_c    = 1'b0;
        ram_waddr_c = wr_addr;
        ram_wdata_c = user_word_c;
        case (state_q)
            INIT: begin
                ram_we_c    = 1'b1;
                ram_waddr_c = init_addr_q;
                ram_wdata_c = init_word_c;
                init_addr_d = init_addr_q + IDX_W'(1);
                if (init_addr_q == IDX_W'(ENTRIES - 1)) begin
                    state_d     = RUN;
                    init_addr_d = '0;
                end
            end
            RUN: begin
                ram_we_c = wr_en;
            end
            default: begin
                state_d = INIT;
            end
        endcase
        if (rst) begin
            ram_we_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            init_addr_q <= '0;
            init_busy_q <= 1'b1;
            wr_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            init_busy_q <= (state_d == INIT);
            wr_ready_q  <= (state_d == RUN);
        end
    end

    vga_console_palette_ram #(
        .ADDR_W (IDX_W),
        .DATA_W (MEM_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_c),
        .waddr_i (ram_waddr_c),
        .wdata_i (ram_wdata_c),
        .raddr_i (color_idx),
        .rdata_o (rd_data)
    );

    // Output stage: blank reads that were issued while the palette was loading.
    always_comb begin
        rgb_d = rd_data[RGB_W-1:0];
`ifdef VGA_CONSOLE_PALETTE_BLINK_EN
        if (rd_data[RGB_W] && blink_s1_q) begin
            rgb_d = '0;
        end
`endif
        if (init_s1_q) begin
            rgb_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_s1_q  <= 1'b0;
            rgb_valid_q <= 1'b0;
            init_s1_q   <= 1'b1;
            rgb_q       <= '0;
`ifdef VGA_CONSOLE_PALETTE_BLINK_EN
            blink_s1_q  <= 1'b0;
`endif
        end else begin
            valid_s1_q  <= pix_valid;
            rgb_valid_q <= valid_s1_q;
            init_s1_q   <= (state_q == INIT);
            rgb_q       <= rgb_d;
`ifdef VGA_CONSOLE_PALETTE_BLINK_EN
            blink_s1_q  <= blink_phase;
`endif
        end
    end

    assign rgb_valid = rgb_valid_q;
    assign rgb       = rgb_q;
    assign init_busy = init_busy_q;
    assign wr_ready  = wr_ready_q;

endmodule

// File: tb/tb_vga_console_palette_lut.sv
// Self-checking bench for vga_console_palette_lut (4/3/3/2 configuration).
module tb_vga_console_palette_lut;

    localparam int unsigned ENTRIES = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_valid;
    logic [3:0] color_idx;
    logic       rgb_valid;
    logic [7:0] rgb;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       init_busy;
`ifdef VGA_CONSOLE_PALETTE_BLINK_EN
    logic       blink_phase;
    logic       wr_blink;
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    vga_console_palette_lut #(
        .IDX_W (4),
        .R_W   (3),
        .G_W   (3),
        .B_W   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_valid   (pix_valid),
        .color_idx   (color_idx),
        .rgb_valid   (rgb_valid),
        .rgb         (rgb),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
`ifdef VGA_CONSOLE_PALETTE_BLINK_EN
        .blink_phase (blink_phase),
        .wr_blink    (wr_blink),
`endif
        .wr_ready    (wr_ready),
        .init_busy   (init_busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference state: palette contents, init progress, two-deep output pipe.
    logic [7:0] m_mem [ENTRIES];
    bit         m_blk [ENTRIES];
    int         m_init_cnt = 0;
    logic [7:0] m_s1_rgb   = 8'h00;
    logic [7:0] m_out_rgb  = 8'h00;
    logic       m_s1_v     = 1'b0;
    logic       m_out_v    = 1'b0;

    // Default palette from the colour rules: index bits 2/1/0 pick R/G/B,
    // bit 3 clear means half-scale (MSB of channel only).
    function automatic logic [7:0] ref_default(input int k);
        int r, g, b;
        bit half;
        if (k == 0) return 8'hFF;
        if (k == 1) return 8'h00;
        half = ((k / 8) % 2) == 0;
        r = ((k / 4) % 2 == 1) ? (half ? 4 : 7) : 0;
        g = ((k / 2) % 2 == 1) ? (half ? 4 : 7) : 0;
        b = (k % 2 == 1)       ? (half ? 2 : 3) : 0;
        return 8'(r * 32 + g * 4 + b);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the reference at the edge, check after it.
    task automatic tick(input logic r, input logic pv, input logic [3:0] idx,
                        input logic we, input logic [3:0] wa, input logic [7:0] wd,
                        input logic wb, input logic bp);
        logic       in_init;
        logic [7:0] rd;
        rst       = r;
        pix_valid = pv;
        color_idx = idx;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
`ifdef VGA_CONSOLE_PALETTE_BLINK_EN
        wr_blink    = wb;
        blink_phase = bp;
`endif
        @(posedge clk);
        cyc++;
        if (r) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_mem[k] = ref_default(k);
                m_blk[k] = 1'b0;
            end
            m_init_cnt = 0;
            m_s1_rgb   = 8'h00;
            m_out_rgb  = 8'h00;
            m_s1_v     = 1'b0;
            m_out_v    = 1'b0;
        end else begin
            in_init = (m_init_cnt < ENTRIES);
            rd = m_mem[idx];
            if (BLINK_ON && m_blk[idx] && bp) rd = 8'h00;
            m_out_rgb = m_s1_rgb;
            m_out_v   = m_s1_v;
            m_s1_rgb  = in_init ? 8'h00 : rd;
            m_s1_v    = pv;
            if (!in_init && we) begin
                m_mem[wa] = wd;
                m_blk[wa] = wb;
            end
            if (in_init) m_init_cnt++;
        end
        #1;
        check("rgb",       rgb,               m_out_rgb);
        check("rgb_valid", 8'(rgb_valid),     8'(m_out_v));
        check("init_busy", 8'(init_busy),     8'(m_init_cnt < ENTRIES));
        check("wr_ready",  8'(wr_ready),      8'(m_init_cnt >= ENTRIES));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    endtask

    // Look up every entry back-to-back, then drain the pipeline.
    task automatic sweep();
        for (int i = 0; i < ENTRIES; i++) tick(1'b0, 1'b1, 4'(i), 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        idle(2);
    endtask

    initial begin
        // Reset state.
        tick(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 4'd3, 1'b1, 4'd3, 8'hAA, 1'b0, 1'b0);

        // Init window with lookups and a write that must be dropped.
        for (int i = 0; i < ENTRIES; i++) begin
            tick(1'b0, 1'b1, 4'($urandom_range(15, 0)), (i == 5), 4'd5, 8'h33, 1'b0, 1'b0);
        end
        sweep();

        // Collision: same-cycle lookup sees the old value, next cycle the new one.
        tick(1'b0, 1'b1, 4'd2, 1'b1, 4'd2, 8'h5A, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 4'd2, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        idle(2);

        // Valid pattern 1,0,1,1.
        tick(1'b0, 1'b1, 4'd12, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 4'd4,  1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 4'd15, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 4'd0,  1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        idle(3);

        // Randomized lookups and writes.
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)),
                 ($urandom_range(3, 0) == 0), 4'($urandom_range(15, 0)), 8'($urandom),
                 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end
        sweep();

        // Reset mid-RUN reloads the defaults.
        tick(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < ENTRIES; i++) tick(1'b0, 1'b1, 4'(i), 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        sweep();

        // Reset at init cycle 7 restarts the sequencer from entry 0.
        tick(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, 4'(i), 1'b1, 4'(i), 8'hC3, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < ENTRIES; i++) tick(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        sweep();

        // Blink entry alternates with phase; a plain entry is unaffected.
        tick(1'b0, 1'b0, 4'd0, 1'b1, 4'd3, 8'h1F, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 8'h00, 1'b0, 1'(i & 1));
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 4'd5, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
